// File: rtl/mux_scan_nx1.sv
// rtl/mux_scan_nx1.sv - registered N:1 channel mux with manual/scan select and valid/ready output
module mux_scan_nx1 #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [SW-1:0]   s,
    input  logic [N*W-1:0]  i,
    output logic [W-1:0]    y,
    output logic [SW-1:0]   y_ch,
    output logic            y_valid,
    input  logic            y_ready,
    output logic            err,
    input  logic            clr_err
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [SW:0]   N_EXT = (SW+1)'(N);
    localparam logic [SW-1:0] LAST  = SW'(N-1);

    state_t        state_q, state_d;
    logic [W-1:0]  y_q, y_d;
    logic [SW-1:0] ch_q, ch_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;
    logic          mode_q;

    logic          load;
    logic          restart;
    logic          s_bad;
    logic [SW-1:0] ptr_eff;
    logic [SW-1:0] ch_sel;
    logic [W-1:0]  data_sel;

    assign load    = en && ((state_q == EMPTY) || y_ready);
    // Entering scan mode restarts the sweep at channel 0 in that same cycle.
    assign restart = mode && !mode_q;
    assign ptr_eff = restart ? '0 : ptr_q;
    assign ch_sel  = mode ? ptr_eff : s;
    assign s_bad   = !mode && ({1'b0, s} >= N_EXT);

    // Out-of-range channels match no k, so they naturally select zero.
    always_comb begin
        data_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (ch_sel == SW'(k)) begin
                data_sel = i[k*W +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        ch_d    = ch_q;
        ptr_d   = ptr_eff;
        err_d   = err_q;

        case (state_q)
            EMPTY:   if (load) state_d = FULL;
            FULL:    if (!load && y_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        if (load) begin
            y_d  = data_sel;
            ch_d = ch_sel;
            if (mode) begin
                ptr_d = (ptr_eff == LAST) ? '0 : ptr_eff + SW'(1);
            end
        end

        if (load && s_bad) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            y_q     <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            mode_q  <= mode;
        end
    end

    assign y       = y_q;
    assign y_ch    = ch_q;
    assign y_valid = (state_q == FULL);
    assign err     = err_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb/tb_mux_scan_nx1.sv - scoreboard bench for mux_scan_nx1 (N=4 and N=3 instances)
module tb_mux_scan_nx1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, mode, y_ready, clr_err;
    logic [1:0]  s;
    logic [31:0] i4;
    logic [23:0] i3;
    logic [7:0]  y4, y3;
    logic [1:0]  ch4, ch3;
    logic        v4, v3, err4, err3;

    mux_scan_nx1 #(.N(4), .W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .i(i4),
        .y(y4), .y_ch(ch4), .y_valid(v4), .y_ready(y_ready), .err(err4), .clr_err(clr_err)
    );

    mux_scan_nx1 #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .i(i3),
        .y(y3), .y_ch(ch3), .y_valid(v3), .y_ready(y_ready), .err(err3), .clr_err(clr_err)
    );

    typedef struct packed {
        logic [7:0] y;
        logic [1:0] ch;
    } exp_t;

    exp_t       q4[$];
    exp_t       q3[$];
    logic [7:0] chan[4];
    int         ptr[2];
    bit         mprev[2];
    bit         vnow[2], vnext[2], enow[2], enext[2];
    int         n_cmp = 0;
    int         n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    // Reference: one call describes what the coming clock edge does to instance k.
    task automatic model_step(input int k, input int nn);
        bit   load;
        int   c;
        exp_t e;
        vnow[k] = vnext[k];
        enow[k] = enext[k];
        load = en && (!vnow[k] || y_ready);
        if (mode && !mprev[k]) ptr[k] = 0;
        if (load) begin
            c    = mode ? ptr[k] : int'(s);
            e.ch = 2'(c);
            e.y  = (c < nn) ? chan[c] : 8'h00;
            if (mode) ptr[k] = (ptr[k] + 1) % nn;
            if (k == 0) q4.push_back(e);
            else        q3.push_back(e);
        end
        if (load && !mode && int'(s) >= nn) enext[k] = 1'b1;
        else if (clr_err)                   enext[k] = 1'b0;
        vnext[k] = load ? 1'b1 : (y_ready ? 1'b0 : vnow[k]);
        mprev[k] = mode;
    endtask

    task automatic drive(input bit e, input bit m, input logic [1:0] ss, input bit r, input bit c);
        @(posedge clk);
        #2;
        en = e; mode = m; s = ss; y_ready = r; clr_err = c;
        i4 = {chan[3], chan[2], chan[1], chan[0]};
        i3 = i4[23:0];
        model_step(0, 4);
        model_step(1, 3);
    endtask

    task automatic do_reset();
        en = 1'b0; mode = 1'b0; s = 2'd0; y_ready = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_y4", y4, 0);   chk("rst_ch4", ch4, 0);
        chk("rst_v4", v4, 0);   chk("rst_err4", err4, 0);
        chk("rst_y3", y3, 0);   chk("rst_ch3", ch3, 0);
        chk("rst_v3", v3, 0);   chk("rst_err3", err3, 0);
        for (int k = 0; k < 2; k++) begin
            ptr[k] = 0; mprev[k] = 1'b0; vnext[k] = 1'b0; enext[k] = 1'b0;
        end
        q4.delete();
        q3.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_step(0, 4);
        model_step(1, 3);
    endtask

    task automatic check_inst(input int k);
        logic [7:0] ya;
        logic [1:0] ca;
        logic       va, ea;
        exp_t       e;
        bit         empty;
        ya = (k == 0) ? y4 : y3;
        ca = (k == 0) ? ch4 : ch3;
        va = (k == 0) ? v4 : v3;
        ea = (k == 0) ? err4 : err3;
        chk(k == 0 ? "valid4" : "valid3", va, vnow[k]);
        chk(k == 0 ? "err4" : "err3", ea, enow[k]);
        if (va === 1'b1 && y_ready === 1'b1) begin
            empty = (k == 0) ? (q4.size() == 0) : (q3.size() == 0);
            if (empty) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_sample inst %0d at %0t: got y=%0h ch=%0d expected none", k, $time, ya, ca);
            end else begin
                e = (k == 0) ? q4.pop_front() : q3.pop_front();
                chk(k == 0 ? "y4" : "y3", ya, e.y);
                chk(k == 0 ? "ych4" : "ych3", ca, e.ch);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_inst(0);
            check_inst(1);
        end
    end

    initial begin
        rst_n = 1'b1; en = 1'b0; mode = 1'b0; s = 2'd0; y_ready = 1'b0; clr_err = 1'b0;
        i4 = '0; i3 = '0;
        chan[0] = 8'h11; chan[1] = 8'h22; chan[2] = 8'h33; chan[3] = 8'h44;
        do_reset();

        drive(1, 0, 2'd2, 1, 0);
        repeat (6) drive(1, 1, 2'd0, 1, 0);
        repeat (3) drive(1, 1, 2'd0, 0, 0);
        repeat (3) drive(1, 1, 2'd0, 1, 0);
        drive(1, 0, 2'd3, 1, 0);
        drive(1, 0, 2'd0, 1, 1);
        drive(0, 0, 2'd0, 1, 0);
        repeat (2) drive(1, 1, 2'd0, 1, 0);
        drive(1, 0, 2'd1, 1, 0);
        repeat (4) drive(1, 1, 2'd0, 1, 0);
        drive(1, 1, 2'd0, 0, 0);
        do_reset();
        repeat (5) drive(1, 1, 2'd0, 1, 0);

        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 4; c++) chan[c] = 8'($urandom);
            if (n == 700) begin
                drive(1, 1, 2'd0, 0, 0);
                drive(1, 1, 2'd0, 0, 0);
                do_reset();
            end
            drive(($urandom_range(0, 9) < 8), (($urandom_range(0, 15) == 0) ? !mode : mode),
                  2'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
        end
        repeat (4) drive(0, 0, 2'd0, 1, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
